// File: rtl/vadd_ctrl_master_if.sv
// AXI4-Lite bus between the vadd control master and the kernel control slave.
// Latency: none, plain wires grouped for port connection.
// Backpressure: standard AXI valid/ready on each of the five channels.
interface vadd_ctrl_master_if #(
  parameter int C_ADDR_WIDTH = 12
) ();
  logic                    m_awvalid;
  logic                    m_awready;
  logic [C_ADDR_WIDTH-1:0] m_awaddr;
  logic                    m_wvalid;
  logic                    m_wready;
  logic [31:0]             m_wdata;
  logic [3:0]              m_wstrb;
  logic                    m_bvalid;
  logic                    m_bready;
  logic [1:0]              m_bresp;
  logic                    m_arvalid;
  logic                    m_arready;
  logic [C_ADDR_WIDTH-1:0] m_araddr;
  logic                    m_rvalid;
  logic                    m_rready;
  logic [31:0]             m_rdata;
  logic [1:0]              m_rresp;

  modport master (
    output m_awvalid, m_awaddr, m_wvalid, m_wdata, m_wstrb, m_bready,
    output m_arvalid, m_araddr, m_rready,
    input  m_awready, m_wready, m_bvalid, m_bresp,
    input  m_arready, m_rvalid, m_rdata, m_rresp
  );

  modport slave (
    input  m_awvalid, m_awaddr, m_wvalid, m_wdata, m_wstrb, m_bready,
    input  m_arvalid, m_araddr, m_rready,
    output m_awready, m_wready, m_bvalid, m_bresp,
    output m_arready, m_rvalid, m_rdata, m_rresp
  );
endinterface

// File: rtl/vadd_ctrl_master.sv
// AXI4-Lite master: writes a/b/c/len, sets ap_start, polls ap_done, pulses done.
// Latency: AW/W one cycle after accept; 2 cycles per write with a fast slave.
// Backpressure: one AXI transaction outstanding; cmd_ready only in IDLE.
module vadd_ctrl_master #(
  parameter int C_ADDR_WIDTH = 12,
  parameter int C_PTR_WIDTH  = 64,
  parameter int POLL_GAP     = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [C_PTR_WIDTH-1:0] cmd_a,
  input  logic [C_PTR_WIDTH-1:0] cmd_b,
  input  logic [C_PTR_WIDTH-1:0] cmd_c,
  input  logic [31:0]            cmd_len,
  output logic                   done,
  output logic                   err,
  output logic                   busy,
  vadd_ctrl_master_if.master     m_axil
);

  localparam logic [7:0] ADDR_CTRL = 8'h00;
  localparam logic [7:0] ADDR_A_LO = 8'h10;
  localparam logic [7:0] ADDR_A_HI = 8'h14;
  localparam logic [7:0] ADDR_B_LO = 8'h1C;
  localparam logic [7:0] ADDR_B_HI = 8'h20;
  localparam logic [7:0] ADDR_C_LO = 8'h28;
  localparam logic [7:0] ADDR_C_HI = 8'h2C;
  localparam logic [7:0] ADDR_LEN  = 8'h34;

  typedef enum logic [2:0] {
    S_IDLE, S_WR_REQ, S_WR_RESP, S_RD_REQ, S_RD_RESP, S_GAP, S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [2:0]              idx_q, idx_d;
  logic                    err_flag_q, err_flag_d;
  logic [31:0]             gap_q, gap_d;
  logic [C_PTR_WIDTH-1:0]  a_q, a_d, b_q, b_d, c_q, c_d;
  logic [31:0]             len_q, len_d;
  logic                    awvalid_q, awvalid_d;
  logic                    wvalid_q, wvalid_d;
  logic [C_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic                    bready_q, bready_d;
  logic                    arvalid_q, arvalid_d;
  logic                    rready_q, rready_d;
  logic                    done_q, done_d;
  logic                    err_out_q, err_out_d;
  logic                    busy_q, busy_d;
  logic                    cmd_ready_q, cmd_ready_d;
  logic                    aw_ok, w_ok;

  // Only ap_done is inspected in the status word.
  logic unused_rdata;
  assign unused_rdata = ^{m_axil.m_rdata[31:2], m_axil.m_rdata[0]};

  // Register offset for each step of the write sequence; index 7 is ap_start.
  function automatic logic [C_ADDR_WIDTH-1:0] wr_addr(input logic [2:0] idx);
    logic [7:0] a;
    case (idx)
      3'd0:    a = ADDR_A_LO;
      3'd1:    a = ADDR_A_HI;
      3'd2:    a = ADDR_B_LO;
      3'd3:    a = ADDR_B_HI;
      3'd4:    a = ADDR_C_LO;
      3'd5:    a = ADDR_C_HI;
      3'd6:    a = ADDR_LEN;
      default: a = ADDR_CTRL;
    endcase
    return C_ADDR_WIDTH'(a);
  endfunction

  // Data word for each step; pointers are zero-extended to 64 bits first.
  function automatic logic [31:0] wr_word(input logic [2:0] idx,
                                          input logic [63:0] a,
                                          input logic [63:0] b,
                                          input logic [63:0] c,
                                          input logic [31:0] len);
    case (idx)
      3'd0:    return a[31:0];
      3'd1:    return a[63:32];
      3'd2:    return b[31:0];
      3'd3:    return b[63:32];
      3'd4:    return c[31:0];
      3'd5:    return c[63:32];
      3'd6:    return len;
      default: return 32'h1;
    endcase
  endfunction

  // Next state and next values of every registered output.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    err_flag_d = err_flag_q;
    gap_d      = gap_q;
    a_d        = a_q;
    b_d        = b_q;
    c_d        = c_q;
    len_d      = len_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    bready_d   = 1'b0;
    arvalid_d  = 1'b0;
    rready_d   = 1'b0;
    aw_ok      = !awvalid_q || m_axil.m_awready;
    w_ok       = !wvalid_q || m_axil.m_wready;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          a_d        = cmd_a;
          b_d        = cmd_b;
          c_d        = cmd_c;
          len_d      = cmd_len;
          idx_d      = 3'd0;
          err_flag_d = 1'b0;
          awvalid_d  = 1'b1;
          wvalid_d   = 1'b1;
          awaddr_d   = wr_addr(3'd0);
          wdata_d    = wr_word(3'd0, 64'(cmd_a), 64'(cmd_b), 64'(cmd_c), cmd_len);
          state_d    = S_WR_REQ;
        end
      end
      S_WR_REQ: begin
        // AW and W retire independently; move on once both have handshaken.
        if (awvalid_q && m_axil.m_awready) awvalid_d = 1'b0;
        if (wvalid_q && m_axil.m_wready)   wvalid_d  = 1'b0;
        if (aw_ok && w_ok) begin
          bready_d = 1'b1;
          state_d  = S_WR_RESP;
        end
      end
      S_WR_RESP: begin
        bready_d = 1'b1;
        if (m_axil.m_bvalid) begin
          bready_d = 1'b0;
          if (m_axil.m_bresp != 2'b00) begin
            // Abort the sequence: ap_start is never written after a bad write.
            err_flag_d = 1'b1;
            state_d    = S_DONE;
          end else if (idx_q == 3'd7) begin
            arvalid_d = 1'b1;
            state_d   = S_RD_REQ;
          end else begin
            idx_d     = 3'(idx_q + 3'd1);
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            awaddr_d  = wr_addr(3'(idx_q + 3'd1));
            wdata_d   = wr_word(3'(idx_q + 3'd1), 64'(a_q), 64'(b_q), 64'(c_q), len_q);
            state_d   = S_WR_REQ;
          end
        end
      end
      S_RD_REQ: begin
        arvalid_d = 1'b1;
        if (m_axil.m_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RD_RESP;
        end
      end
      S_RD_RESP: begin
        rready_d = 1'b1;
        if (m_axil.m_rvalid) begin
          rready_d = 1'b0;
          if (m_axil.m_rresp != 2'b00) begin
            err_flag_d = 1'b1;
            state_d    = S_DONE;
          end else if (m_axil.m_rdata[1]) begin
            state_d = S_DONE;
          end else if (POLL_GAP == 0) begin
            arvalid_d = 1'b1;
            state_d   = S_RD_REQ;
          end else begin
            gap_d   = 32'(POLL_GAP - 1);
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (gap_q == 32'd0) begin
          arvalid_d = 1'b1;
          state_d   = S_RD_REQ;
        end else begin
          gap_d = gap_q - 32'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    done_d      = (state_d == S_DONE);
    err_out_d   = (state_d == S_DONE) && err_flag_d;
    busy_d      = (state_d != S_IDLE);
    cmd_ready_d = (state_d == S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= 3'd0;
      err_flag_q  <= 1'b0;
      gap_q       <= 32'd0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      len_q       <= 32'd0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      awaddr_q    <= '0;
      wdata_q     <= 32'd0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      done_q      <= 1'b0;
      err_out_q   <= 1'b0;
      busy_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      err_flag_q  <= err_flag_d;
      gap_q       <= gap_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      len_q       <= len_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      awaddr_q    <= awaddr_d;
      wdata_q     <= wdata_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      done_q      <= done_d;
      err_out_q   <= err_out_d;
      busy_q      <= busy_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  assign cmd_ready        = cmd_ready_q;
  assign done             = done_q;
  assign err              = err_out_q;
  assign busy             = busy_q;
  assign m_axil.m_awvalid = awvalid_q;
  assign m_axil.m_awaddr  = awaddr_q;
  assign m_axil.m_wvalid  = wvalid_q;
  assign m_axil.m_wdata   = wdata_q;
  assign m_axil.m_wstrb   = 4'hF;
  assign m_axil.m_bready  = bready_q;
  assign m_axil.m_arvalid = arvalid_q;
  assign m_axil.m_araddr  = C_ADDR_WIDTH'(ADDR_CTRL);
  assign m_axil.m_rready  = rready_q;

endmodule

// File: tb/tb_vadd_ctrl_master.sv
// Directed bench for vadd_ctrl_master with a reactive AXI-Lite slave model.
// Latency: checks write spacing, AR-after-B, poll gaps and done timing.
// Backpressure: optional awready lag, error injection on a chosen address.
module tb_vadd_ctrl_master;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [63:0] cmd_a = '0, cmd_b = '0, cmd_c = '0;
  logic [31:0] cmd_len = '0;
  logic        done, err, busy;

  vadd_ctrl_master_if #(.C_ADDR_WIDTH(12)) axil ();

  vadd_ctrl_master #(.C_ADDR_WIDTH(12), .C_PTR_WIDTH(64), .POLL_GAP(4)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_c(cmd_c), .cmd_len(cmd_len),
    .done(done), .err(err), .busy(busy),
    .m_axil(axil.master)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Slave configuration and logs.
  int          aw_lag = 0;
  logic [11:0] err_addr = 12'hFFF;
  int          rd_seq[$];
  int          cyc = 0;
  int          acc_cyc[$], done_cyc[$], b_cyc[$], ar_cyc[$], r_cyc[$];
  logic        done_err[$];
  logic [11:0] aw_log[$];
  logic [31:0] w_log[$];
  logic [3:0]  s_log[$];
  int          aw_first = -1;
  int          stab_viol = 0;
  logic        saw_aw_only = 1'b0;
  int          b_issued = 0, r_issued = 0, aw_age = 0;

  logic        p_awv = 0, p_awhs = 0, p_wv = 0, p_whs = 0;
  logic [11:0] p_awaddr = '0;
  logic [31:0] p_wdata = '0;

  logic [11:0] exp_addr [8] = '{12'h10, 12'h14, 12'h1C, 12'h20, 12'h28, 12'h2C, 12'h34, 12'h00};

  // Mid-cycle monitor: logs handshakes and watches valid-held stability.
  always @(negedge clock) begin
    cyc++;
    if (cmd_valid && cmd_ready) acc_cyc.push_back(cyc);
    if (done) begin done_cyc.push_back(cyc); done_err.push_back(err); end
    if (axil.m_awvalid && aw_first < 0) aw_first = cyc;
    if (!reset) begin
      if (p_awv && !p_awhs && (!axil.m_awvalid || axil.m_awaddr != p_awaddr)) stab_viol++;
      if (p_wv && !p_whs && (!axil.m_wvalid || axil.m_wdata != p_wdata)) stab_viol++;
    end
    if (axil.m_awvalid && !axil.m_wvalid) saw_aw_only = 1'b1;
    if (axil.m_awvalid && axil.m_awready) aw_log.push_back(axil.m_awaddr);
    if (axil.m_wvalid && axil.m_wready) begin
      w_log.push_back(axil.m_wdata);
      s_log.push_back(axil.m_wstrb);
    end
    if (axil.m_bvalid && axil.m_bready)   b_cyc.push_back(cyc);
    if (axil.m_arvalid && axil.m_arready) ar_cyc.push_back(cyc);
    if (axil.m_rvalid && axil.m_rready)   r_cyc.push_back(cyc);
    p_awv = axil.m_awvalid; p_awhs = axil.m_awvalid && axil.m_awready;
    p_wv  = axil.m_wvalid;  p_whs  = axil.m_wvalid && axil.m_wready;
    p_awaddr = axil.m_awaddr; p_wdata = axil.m_wdata;
  end

  // Reactive slave, updated 2 time units after each rising edge.
  initial begin
    axil.m_awready = 1'b1; axil.m_wready = 1'b1; axil.m_arready = 1'b1;
    axil.m_bvalid = 1'b0; axil.m_bresp = 2'b00;
    axil.m_rvalid = 1'b0; axil.m_rdata = 32'd0; axil.m_rresp = 2'b00;
    forever begin
      @(posedge clock); #2;
      if (reset) begin
        axil.m_bvalid = 1'b0; axil.m_rvalid = 1'b0;
        b_issued = aw_log.size(); r_issued = ar_cyc.size(); aw_age = 0;
      end else begin
        if (axil.m_awvalid) aw_age++; else aw_age = 0;
        axil.m_awready = (aw_lag == 0) || (axil.m_awvalid && aw_age > aw_lag);
        if (axil.m_bvalid && b_cyc.size() == b_issued) axil.m_bvalid = 1'b0;
        if (!axil.m_bvalid && aw_log.size() == w_log.size() && aw_log.size() > b_issued) begin
          axil.m_bresp  = (aw_log[aw_log.size()-1] == err_addr) ? 2'b10 : 2'b00;
          axil.m_bvalid = 1'b1;
          b_issued++;
        end
        if (axil.m_rvalid && r_cyc.size() == r_issued) axil.m_rvalid = 1'b0;
        if (!axil.m_rvalid && ar_cyc.size() > r_issued) begin
          axil.m_rdata  = (r_issued < rd_seq.size()) ? 32'(rd_seq[r_issued]) : 32'h2;
          axil.m_rvalid = 1'b1;
          r_issued++;
        end
      end
    end
  end

  task automatic clear_logs();
    acc_cyc.delete(); done_cyc.delete(); done_err.delete(); b_cyc.delete();
    ar_cyc.delete(); r_cyc.delete(); aw_log.delete(); w_log.delete(); s_log.delete();
    aw_first = -1; stab_viol = 0; saw_aw_only = 1'b0;
    b_issued = 0; r_issued = 0; aw_age = 0;
    axil.m_bvalid = 1'b0; axil.m_rvalid = 1'b0;
  endtask

  task automatic start_cmd(input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] c, input logic [31:0] len);
    int lim = 50;
    int n0 = acc_cyc.size();
    cmd_a = a; cmd_b = b; cmd_c = c; cmd_len = len; cmd_valid = 1'b1;
    do begin @(posedge clock); #1; lim--; end while (acc_cyc.size() == n0 && lim > 0);
    cmd_valid = 1'b0;
    n_cmp++;
    if (acc_cyc.size() == n0) begin
      n_bad++; $display("FAIL accept_timeout: accepts=%0d required>%0d", acc_cyc.size(), n0);
    end
  endtask

  task automatic wait_done(input int n);
    int lim = 2000;
    while (done_cyc.size() < n && lim > 0) begin @(posedge clock); #1; lim--; end
    repeat (4) @(posedge clock);
    #1;
    n_cmp++;
    if (done_cyc.size() != n) begin
      n_bad++; $display("FAIL done_count: got %0d required %0d", done_cyc.size(), n);
    end
  endtask

  task automatic test_reset();
    n_cmp++;
    if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rst_cmd_ready: got %b required 1", cmd_ready); end
    n_cmp++;
    if ({busy, done, err} !== 3'b000) begin n_bad++; $display("FAIL rst_status: got %b required 000", {busy, done, err}); end
    n_cmp++;
    if ({axil.m_awvalid, axil.m_wvalid, axil.m_arvalid, axil.m_bready, axil.m_rready} !== 5'b0) begin
      n_bad++; $display("FAIL rst_valids: got %b required 00000",
        {axil.m_awvalid, axil.m_wvalid, axil.m_arvalid, axil.m_bready, axil.m_rready});
    end
    n_cmp++;
    if ({axil.m_awaddr, axil.m_wdata, axil.m_araddr} !== 56'd0) begin
      n_bad++; $display("FAIL rst_addr_data: awaddr=%h wdata=%h araddr=%h required 0",
        axil.m_awaddr, axil.m_wdata, axil.m_araddr);
    end
  endtask

  task automatic test_basic();
    logic [31:0] ed [8] = '{32'h1000, 32'h0, 32'h2000, 32'h0, 32'h3000, 32'h0, 32'd16, 32'h1};
    clear_logs(); aw_lag = 0; err_addr = 12'hFFF; rd_seq = '{2};
    start_cmd(64'h1000, 64'h2000, 64'h3000, 32'd16);
    wait_done(1);
    n_cmp++;
    if (aw_log.size() != 8 || w_log.size() != 8) begin
      n_bad++; $display("FAIL basic_wr_count: aw=%0d w=%0d required 8", aw_log.size(), w_log.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_cmp++;
        if (aw_log[i] !== exp_addr[i] || w_log[i] !== ed[i] || s_log[i] !== 4'hF) begin
          n_bad++; $display("FAIL basic_wr%0d: got (%h,%h,%h) required (%h,%h,f)",
            i, aw_log[i], w_log[i], s_log[i], exp_addr[i], ed[i]);
        end
      end
    end
    n_cmp++;
    if (ar_cyc.size() != 1) begin n_bad++; $display("FAIL basic_ar_count: got %0d required 1", ar_cyc.size()); end
    n_cmp++;
    if (done_err.size() != 1 || done_err[0] !== 1'b0) begin n_bad++; $display("FAIL basic_err: got %0d entries required err=0", done_err.size()); end
    if (acc_cyc.size() == 1 && b_cyc.size() == 8 && ar_cyc.size() == 1 && done_cyc.size() == 1) begin
      n_cmp++;
      if (aw_first != acc_cyc[0] + 1) begin n_bad++; $display("FAIL basic_aw_latency: got %0d required %0d", aw_first - acc_cyc[0], 1); end
      n_cmp++;
      if (b_cyc[7] - acc_cyc[0] != 16) begin n_bad++; $display("FAIL basic_wr_cycles: got %0d required 16", b_cyc[7] - acc_cyc[0]); end
      n_cmp++;
      if (ar_cyc[0] != b_cyc[7] + 1) begin n_bad++; $display("FAIL basic_ar_after_b: got %0d required 1", ar_cyc[0] - b_cyc[7]); end
      n_cmp++;
      if (done_cyc[0] != b_cyc[7] + 3) begin n_bad++; $display("FAIL basic_done_time: got %0d required 3", done_cyc[0] - b_cyc[7]); end
    end else begin
      n_cmp++; n_bad++;
      $display("FAIL basic_log_sizes: acc=%0d b=%0d ar=%0d done=%0d required 1/8/1/1",
        acc_cyc.size(), b_cyc.size(), ar_cyc.size(), done_cyc.size());
    end
  endtask

  task automatic test_polling();
    clear_logs(); rd_seq = '{0, 0, 0, 2};
    start_cmd(64'h4000, 64'h5000, 64'h6000, 32'd8);
    wait_done(1);
    n_cmp++;
    if (ar_cyc.size() != 4 || r_cyc.size() != 4) begin
      n_bad++; $display("FAIL poll_count: ar=%0d r=%0d required 4", ar_cyc.size(), r_cyc.size());
    end else begin
      for (int i = 1; i < 4; i++) begin
        n_cmp++;
        if (ar_cyc[i] - r_cyc[i-1] - 1 < 4) begin
          n_bad++; $display("FAIL poll_gap%0d: idle %0d required >=4", i, ar_cyc[i] - r_cyc[i-1] - 1);
        end
      end
      n_cmp++;
      if (done_cyc.size() != 1 || done_cyc[0] != r_cyc[3] + 1) begin
        n_bad++; $display("FAIL poll_done_time: done entries %0d required 1 cycle after 4th R", done_cyc.size());
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] ed [8] = '{32'hA000, 32'h1, 32'hB000, 32'h2, 32'hC000, 32'hCAFE0003, 32'd100, 32'h1};
    clear_logs(); aw_lag = 3; rd_seq = '{2};
    start_cmd(64'h0000_0001_0000_A000, 64'h0000_0002_0000_B000, 64'hCAFE_0003_0000_C000, 32'd100);
    wait_done(1);
    aw_lag = 0;
    n_cmp++;
    if (stab_viol != 0) begin n_bad++; $display("FAIL bp_stability: violations %0d required 0", stab_viol); end
    n_cmp++;
    if (saw_aw_only !== 1'b1) begin n_bad++; $display("FAIL bp_wvalid_drop: got %b required 1", saw_aw_only); end
    n_cmp++;
    if (aw_log.size() != 8 || w_log.size() != 8) begin
      n_bad++; $display("FAIL bp_wr_count: aw=%0d w=%0d required 8", aw_log.size(), w_log.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_cmp++;
        if (aw_log[i] !== exp_addr[i] || w_log[i] !== ed[i]) begin
          n_bad++; $display("FAIL bp_wr%0d: got (%h,%h) required (%h,%h)", i, aw_log[i], w_log[i], exp_addr[i], ed[i]);
        end
      end
    end
  endtask

  task automatic test_write_error();
    clear_logs(); err_addr = 12'h01C; rd_seq = '{2};
    start_cmd(64'h1000, 64'h2000, 64'h3000, 32'd4);
    wait_done(1);
    n_cmp++;
    if (aw_log.size() != 3 || w_log.size() != 3) begin
      n_bad++; $display("FAIL werr_wr_count: aw=%0d w=%0d required 3", aw_log.size(), w_log.size());
    end
    n_cmp++;
    if (ar_cyc.size() != 0) begin n_bad++; $display("FAIL werr_no_ar: got %0d required 0", ar_cyc.size()); end
    n_cmp++;
    if (done_err.size() != 1 || done_err[0] !== 1'b1) begin n_bad++; $display("FAIL werr_err: entries %0d required err=1", done_err.size()); end
    clear_logs(); err_addr = 12'hFFF;
    start_cmd(64'h1000, 64'h2000, 64'h3000, 32'd4);
    wait_done(1);
    n_cmp++;
    if (done_err.size() != 1 || done_err[0] !== 1'b0 || aw_log.size() != 8) begin
      n_bad++; $display("FAIL werr_next_clean: err entries %0d writes %0d required err=0 and 8", done_err.size(), aw_log.size());
    end
  endtask

  task automatic test_reset_mid_poll();
    int lim = 300;
    clear_logs(); rd_seq = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    start_cmd(64'h7000, 64'h8000, 64'h9000, 32'd2);
    while (!axil.m_rready && lim > 0) begin @(posedge clock); #1; lim--; end
    n_cmp++;
    if (axil.m_rready !== 1'b1) begin n_bad++; $display("FAIL rmid_reach_rd_resp: rready %b required 1", axil.m_rready); end
    reset = 1'b1;
    @(posedge clock); #1;
    n_cmp++;
    if ({axil.m_awvalid, axil.m_wvalid, axil.m_arvalid, axil.m_bready, axil.m_rready} !== 5'b0) begin
      n_bad++; $display("FAIL rmid_valids: got %b required 00000",
        {axil.m_awvalid, axil.m_wvalid, axil.m_arvalid, axil.m_bready, axil.m_rready});
    end
    n_cmp++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rmid_status: busy=%b cmd_ready=%b required 0/1", busy, cmd_ready); end
    reset = 1'b0;
    @(posedge clock); #1;
    clear_logs(); rd_seq = '{2};
    start_cmd(64'h1000, 64'h2000, 64'h3000, 32'd16);
    wait_done(1);
    n_cmp++;
    if (aw_log.size() != 8 || ar_cyc.size() != 1 || done_err.size() != 1 || done_err[0] !== 1'b0) begin
      n_bad++; $display("FAIL rmid_rerun: writes %0d ars %0d dones %0d required 8/1/1 err=0",
        aw_log.size(), ar_cyc.size(), done_err.size());
    end
  endtask

  task automatic test_back_to_back();
    int lim = 500;
    int dcount = 0;
    clear_logs(); rd_seq = '{2, 2};
    cmd_a = 64'h1000; cmd_b = 64'h2000; cmd_c = 64'h3000; cmd_len = 32'd5;
    cmd_valid = 1'b1;
    while (dcount < 2 && lim > 0) begin
      @(posedge clock); #1; lim--;
      if (done) dcount++;
      if (dcount == 2) cmd_valid = 1'b0;
    end
    cmd_valid = 1'b0;
    repeat (6) @(posedge clock);
    #1;
    n_cmp++;
    if (acc_cyc.size() != 2) begin n_bad++; $display("FAIL b2b_accepts: got %0d required 2", acc_cyc.size()); end
    n_cmp++;
    if (aw_log.size() != 16) begin n_bad++; $display("FAIL b2b_writes: got %0d required 16", aw_log.size()); end
    n_cmp++;
    if (acc_cyc.size() < 2 || done_cyc.size() < 1 || acc_cyc[1] != done_cyc[0] + 1) begin
      n_bad++; $display("FAIL b2b_second_accept: accepts %0d dones %0d required accept 1 cycle after done",
        acc_cyc.size(), done_cyc.size());
    end
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    test_reset();
    reset = 1'b0;
    @(posedge clock); #1;
    test_basic();
    test_polling();
    test_backpressure();
    test_write_error();
    test_reset_mid_poll();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
